mem_bus_arbiter: RTL

- Two-master, one-slave arbiter for the 32-bit native valid/ready memory bus used by the CPU core, memory and address decoder.
- Lets a second bus master (loader/DMA/debug engine) share memory and peripherals with the CPU.
- Round-robin grant, one transaction at a time; grant held until the slave completes.
- Sits between the masters and the memory/address-decoder path.

---
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// mem_bus_arbiter: round-robin two-master arbiter for the 32-bit native valid/ready memory bus.
// Define MEM_BUS_ARBITER_TIMEOUT_EN to force-complete transactions the slave never answers.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m1_valid,
  input  logic        m0_instr,
  input  logic        m1_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic [3:0]  m1_wstrb,
  output logic        m0_ready,
  output logic        m1_ready,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        timeout_hit;
  logic [31:0] resp_rdata;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             timeout_q;

  // Busy-cycle counter restarts on every grant; the error flag is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        busy_cnt <= '0;
      end else begin
        busy_cnt <= busy_cnt + CNT_W'(1);
      end
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // A real slave response in the final cycle wins over the forced error.
  assign timeout_hit = (state != IDLE) && !s_ready && (busy_cnt == CNT_LAST);
  assign timeout_err = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbitration and completion; both-valid ties go to the master not served last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid && (!m1_valid || last_grant)) begin
            state <= BUSY0;
          end else if (m1_valid) begin
            state <= BUSY1;
          end
        end
        BUSY0: begin
          if (s_ready || timeout_hit) begin
            state      <= IDLE;
            last_grant <= 1'b0;
          end
        end
        BUSY1: begin
          if (s_ready || timeout_hit) begin
            state      <= IDLE;
            last_grant <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant      = {state == BUSY1, state == BUSY0};
  assign resp_rdata = timeout_hit ? ERR_RDATA : s_rdata;

  // Request/response steering to the owner; everything reads zero while idle.
  always_comb begin
    s_valid  = 1'b0;
    s_instr  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    case (state)
      BUSY0: begin
        s_valid  = m0_valid && !timeout_hit;
        s_instr  = m0_instr;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready || timeout_hit;
        m0_rdata = resp_rdata;
      end
      BUSY1: begin
        s_valid  = m1_valid && !timeout_hit;
        s_instr  = m1_instr;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready || timeout_hit;
        m1_rdata = resp_rdata;
      end
      default: ;
    endcase
  end

endmodule
